// File: rtl/dht11_pkg.sv
// dht11_pkg: shared state encoding, default timings and checksum helper for the DHT11 emulator
package dht11_pkg;
  typedef enum logic [2:0] {
    IDLE, HOST_LOW, WAIT_REL, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, END_LOW
  } state_t;
  localparam int unsigned US_DIV_DEF       = 50;
  localparam int unsigned START_MIN_US_DEF = 18000;
  localparam int unsigned RESP_WAIT_US_DEF = 30;
  localparam int unsigned ACK_LOW_US_DEF   = 80;
  localparam int unsigned ACK_HIGH_US_DEF  = 80;
  localparam int unsigned BIT_LOW_US_DEF   = 50;
  localparam int unsigned BIT0_HIGH_US_DEF = 26;
  localparam int unsigned BIT1_HIGH_US_DEF = 70;
  localparam int unsigned END_LOW_US_DEF   = 50;
  localparam int unsigned FRAME_BITS       = 40;
  function automatic logic [7:0] csum(input logic [15:0] humi, input logic [15:0] temp);
    return humi[15:8] + humi[7:0] + temp[15:8] + temp[7:0];
  endfunction
  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/dht11_us_tick.sv
// dht11_us_tick: microsecond prescaler, one-cycle tick every DIV clocks, restartable by clr
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   clr  : synchronous restart of the count (next cycle starts a fresh microsecond)
//   tick : high for one cycle at the end of every DIV-cycle period
module dht11_us_tick #(
  parameter int unsigned DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = cnt_q == W'(DIV - 1);
    cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/dht11_sensor_emu.sv
// dht11_sensor_emu: open-drain single-wire responder emulating a DHT11 sensor
//   clk_50m      : system clock
//   rst          : asynchronous active-high reset, releases the bus immediately
//   dht11_io     : open-drain bus, only ever driven 0 or z
//   i_humi       : humidity {integer, fraction}, latched when the frame starts
//   i_temp       : temperature {integer, fraction}, latched when the frame starts
//   o_busy       : high from acknowledge start until the end low completes
//   o_start_det  : one-cycle pulse when a host start is accepted
//   o_frame_done : one-cycle pulse after the trailing low completes
module dht11_sensor_emu
  import dht11_pkg::*;
#(
  parameter int unsigned US_DIV       = US_DIV_DEF,
  parameter int unsigned START_MIN_US = START_MIN_US_DEF,
  parameter int unsigned RESP_WAIT_US = RESP_WAIT_US_DEF,
  parameter int unsigned ACK_LOW_US   = ACK_LOW_US_DEF,
  parameter int unsigned ACK_HIGH_US  = ACK_HIGH_US_DEF,
  parameter int unsigned BIT_LOW_US   = BIT_LOW_US_DEF,
  parameter int unsigned BIT0_HIGH_US = BIT0_HIGH_US_DEF,
  parameter int unsigned BIT1_HIGH_US = BIT1_HIGH_US_DEF,
  parameter int unsigned END_LOW_US   = END_LOW_US_DEF
) (
  input  logic        clk_50m,
  input  logic        rst,
  inout  wire         dht11_io,
  input  logic [15:0] i_humi,
  input  logic [15:0] i_temp,
  output logic        o_busy,
  output logic        o_start_det,
  output logic        o_frame_done
);
  localparam int unsigned MAX_US = umax(umax(umax(START_MIN_US, RESP_WAIT_US), umax(ACK_LOW_US, ACK_HIGH_US)),
                                        umax(umax(BIT_LOW_US, END_LOW_US), umax(BIT0_HIGH_US, BIT1_HIGH_US)));
  localparam int unsigned UW = $clog2(MAX_US + 1);
  localparam int unsigned IW = $clog2(FRAME_BITS);
  state_t                  state_q, state_d;
  logic [UW-1:0]           us_q, us_d, dur;
  logic [IW-1:0]           idx_q, idx_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic [1:0]              sync_q, sync_d;
  logic                    start_det_q, start_det_d, frame_done_q, frame_done_d;
  logic                    tick, enter, t_done, accept, bus_s, drive_low;
  dht11_us_tick #(.DIV(US_DIV)) u_tick (
    .clk  (clk_50m),
    .rst  (rst),
    .clr  (enter),
    .tick (tick)
  );
  assign bus_s     = sync_q[1];
  assign drive_low = state_q inside {ACK_LOW, BIT_LOW, END_LOW};
  assign dht11_io  = drive_low ? 1'b0 : 1'bz;
  assign o_busy       = state_q inside {ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, END_LOW};
  assign o_start_det  = start_det_q;
  assign o_frame_done = frame_done_q;
  always_comb begin
    sync_d = {sync_q[0], dht11_io};
    dur = (state_q == WAIT_REL) ? UW'(RESP_WAIT_US) :
          (state_q == ACK_LOW)  ? UW'(ACK_LOW_US)   :
          (state_q == ACK_HIGH) ? UW'(ACK_HIGH_US)  :
          (state_q == BIT_LOW)  ? UW'(BIT_LOW_US)   :
          (state_q == BIT_HIGH) ? (frame_q[idx_q] ? UW'(BIT1_HIGH_US) : UW'(BIT0_HIGH_US)) :
                                  UW'(END_LOW_US);
    t_done = tick && (us_q == dur - 1'b1);
    // The release is seen in the cycle that completes the last microsecond, so a pending tick counts.
    accept = (us_q == UW'(START_MIN_US)) || (tick && us_q == UW'(START_MIN_US - 1));
    state_d      = state_q;
    idx_d        = idx_q;
    frame_d      = frame_q;
    start_det_d  = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE:     if (!bus_s) state_d = HOST_LOW;
      HOST_LOW: if (bus_s) begin
                  state_d     = accept ? WAIT_REL : IDLE;
                  start_det_d = accept;
                end
      WAIT_REL: if (t_done) begin
                  state_d = ACK_LOW;
                  frame_d = {i_humi, i_temp, csum(i_humi, i_temp)};
                  idx_d   = IW'(FRAME_BITS - 1);
                end
      ACK_LOW:  if (t_done) state_d = ACK_HIGH;
      ACK_HIGH: if (t_done) state_d = BIT_LOW;
      BIT_LOW:  if (t_done) state_d = BIT_HIGH;
      BIT_HIGH: if (t_done) begin
                  state_d = (idx_q == '0) ? END_LOW : BIT_LOW;
                  idx_d   = (idx_q == '0) ? idx_q : idx_q - 1'b1;
                end
      END_LOW:  if (t_done) begin
                  state_d      = IDLE;
                  frame_done_d = 1'b1;
                end
      default:  state_d = IDLE;
    endcase
    enter = state_d != state_q;
    us_d  = (tick && state_q != IDLE && !(state_q == HOST_LOW && us_q == UW'(START_MIN_US))) ? us_q + 1'b1 : us_q;
    if (enter) us_d = '0;
  end
  always_ff @(posedge clk_50m or posedge rst)
    if (rst) begin
      state_q      <= IDLE;
      us_q         <= '0;
      idx_q        <= '0;
      frame_q      <= '0;
      sync_q       <= 2'b11;
      start_det_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      us_q         <= us_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      sync_q       <= sync_d;
      start_det_q  <= start_det_d;
      frame_done_q <= frame_done_d;
    end
endmodule

// File: tb/tb_dht11_sensor_emu.sv
// tb_dht11_sensor_emu: directed bench acting as DHT11 host, decoding and timing every reply
module tb_dht11_sensor_emu;
  import dht11_pkg::*;
  localparam int DIV  = 2;
  localparam int SMIN = 200;
  logic        clk_50m = 1'b0;
  logic        rst = 1'b1;
  logic        host_low = 1'b0;
  logic [15:0] i_humi = '0, i_temp = '0;
  logic        o_busy, o_start_det, o_frame_done;
  logic        bus;
  logic [39:0] d;
  wire         dht11_io;
  int checks = 0, errors = 0, n_start = 0, n_done = 0, lows, dn;
  pullup (dht11_io);
  assign dht11_io = host_low ? 1'b0 : 1'bz;
  assign bus = (dht11_io === 1'b0) ? 1'b0 : 1'b1;
  dht11_sensor_emu #(.US_DIV(DIV), .START_MIN_US(SMIN)) dut (
    .clk_50m      (clk_50m),
    .rst          (rst),
    .dht11_io     (dht11_io),
    .i_humi       (i_humi),
    .i_temp       (i_temp),
    .o_busy       (o_busy),
    .o_start_det  (o_start_det),
    .o_frame_done (o_frame_done)
  );
  always #5 clk_50m = ~clk_50m;
  always @(negedge clk_50m) begin
    if (o_start_det) n_start++;
    if (o_frame_done) n_done++;
  end
  initial begin
    #3ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic tick1();
    @(posedge clk_50m);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_len(input logic lvl, output int n);
    n = 0;
    do begin
      tick1();
      n++;
    end while (bus === lvl && n < 20000);
  endtask
  task automatic host_start(input int us);
    tick1();
    host_low = 1'b1;
    repeat (us * DIV) tick1();
    host_low = 1'b0;
  endtask
  task automatic quiet(input int cyc);
    lows = 0;
    repeat (cyc) begin
      tick1();
      if (!bus) lows++;
    end
  endtask
  task automatic recv(input int stop_bit, input int mod_bit, input logic [39:0] ef, output logic [39:0] r);
    int n;
    r = '0;
    run_len(1'b1, n); chk("ack_gap", n, 30 * DIV + 3);
    chk("busy_ack", o_busy, 1'b1);
    run_len(1'b0, n); chk("ack_low", n, 80 * DIV);
    run_len(1'b1, n); chk("ack_high", n, 80 * DIV);
    for (int i = 0; i < 40; i++) begin
      if (i == mod_bit) i_temp = 16'h0000;
      if (i == stop_bit) return;
      run_len(1'b0, n); chk("bit_low", n, 50 * DIV);
      run_len(1'b1, n); chk("bit_high", n, ef[39-i] ? 70 * DIV : 26 * DIV);
      r[39-i] = (n == 70 * DIV);
    end
    run_len(1'b0, n); chk("end_low", n, 50 * DIV);
    chk("frame_done", o_frame_done, 1'b1);
    chk("busy_end", o_busy, 1'b0);
    tick1();
    chk("done_width", o_frame_done, 1'b0);
  endtask
  initial begin
    repeat (3) tick1();
    chk("rst_bus", bus, 1'b1);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_start", o_start_det, 1'b0);
    chk("rst_done", o_frame_done, 1'b0);
    chk("rst_state", dut.state_q, IDLE);
    rst = 1'b0;
    repeat (4) tick1();
    host_start(SMIN / 2);
    quiet(60 * DIV);
    chk("short_nolow", lows, 0);
    chk("short_nostart", n_start, 0);
    chk("short_state", dut.state_q, IDLE);
    host_start(SMIN - 1);
    quiet(60 * DIV);
    chk("thr_m1_nolow", lows, 0);
    chk("thr_m1_nostart", n_start, 0);
    i_humi = 16'h3700;
    i_temp = 16'h1905;
    host_start(SMIN + 20);
    recv(-1, -1, 40'h3700190555, d);
    chk("nom_frame", d, 40'h3700190555);
    chk("nom_start", n_start, 1);
    chk("nom_done", n_done, 1);
    i_humi = 16'hFFFF;
    i_temp = 16'hFF01;
    host_start(SMIN);
    recv(-1, -1, 40'hFFFFFF01FE, d);
    chk("thr_exact_start", n_start, 2);
    chk("csum_frame", d, 40'hFFFFFF01FE);
    i_humi = 16'h3700;
    i_temp = 16'h1905;
    host_start(SMIN + 20);
    recv(-1, 10, 40'h3700190555, d);
    chk("latch_inflight", d, 40'h3700190555);
    host_start(SMIN + 20);
    recv(-1, -1, 40'h3700000037, d);
    chk("latch_next", d, 40'h3700000037);
    i_temp = 16'h1905;
    host_start(SMIN + 20);
    recv(20, -1, 40'h3700190555, d);
    chk("mid_low_before_rst", bus, 1'b0);
    dn = n_done;
    rst = 1'b1;
    #1;
    chk("rst_mid_bus", bus, 1'b1);
    chk("rst_mid_busy", o_busy, 1'b0);
    repeat (5) tick1();
    rst = 1'b0;
    quiet(400);
    chk("rst_mid_nolow", lows, 0);
    chk("rst_mid_nodone", n_done, dn);
    chk("rst_mid_state", dut.state_q, IDLE);
    host_start(SMIN);
    recv(-1, -1, 40'h3700190555, d);
    chk("after_rst_frame", d, 40'h3700190555);
    chk("total_starts", n_start, 6);
    chk("total_done", n_done, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dht11_sensor_emu.md
Name: dht11_sensor_emu

Overview:
Single-wire responder that behaves as a DHT11 sensor on the open-drain dht11_io bus.
- Detects the host start pulse.
- Replies with the sensor acknowledge followed by a 40-bit frame built from register inputs: humidity, temperature, checksum.
- Used for loopback and bench checks of the dht11 reader, and as a stand-in sensor on boards without the part fitted.

Parameters:
US_DIV, 50, clk_50m cycles per microsecond tick.
START_MIN_US, 18000, minimum host low time (µs) accepted as a start request.
RESP_WAIT_US, 30, delay after host release before the acknowledge begins.
ACK_LOW_US, 80, acknowledge low time.
ACK_HIGH_US, 80, acknowledge released time.
BIT_LOW_US, 50, low preamble of every bit.
BIT0_HIGH_US, 26, released time for a 0 bit.
BIT1_HIGH_US, 70, released time for a 1 bit.
END_LOW_US, 50, trailing low time after bit 39.

Ports:
clk_50m  in  1  system clock, 50 MHz.
rst  in  1  asynchronous, active-high reset.
dht11_io  inout  1  open-drain bus: driven 1'b0 or 1'bz, never driven 1.
i_humi  in  16  humidity {integer, fraction}, sampled at frame start.
i_temp  in  16  temperature {integer, fraction}, sampled at frame start.
o_busy  out  1  high from acknowledge start until the frame ends.
o_start_det  out  1  one-cycle pulse when a valid start is accepted.
o_frame_done  out  1  one-cycle pulse when END_LOW completes.

Behaviour:
Interface and reset:
- One clock, clk_50m.
- rst is asynchronous, active-high.
- While rst is high: bus released (z), state IDLE, o_busy=0, o_start_det=0, o_frame_done=0, all counters 0.

Timing base:
- Bus input passes through a 2-FF synchroniser.
- A prescaler produces a µs tick every US_DIV cycles and is cleared on every state entry.
- A state lasting N µs therefore occupies exactly N*US_DIV cycles, ±0.

Host start detection:
- IDLE: wait for synced bus = 0, then enter HOST_LOW with the µs counter at 0.
- HOST_LOW: count µs, saturating at START_MIN_US.
  - Bus returns to 1 with count < START_MIN_US: back to IDLE, no pulse.
  - Bus returns to 1 with count = START_MIN_US: pulse o_start_det, enter WAIT_REL.

Acknowledge and data:
- WAIT_REL (bus released, RESP_WAIT_US):
  - Latch frame = {i_humi, i_temp, csum}.
  - csum = (i_humi[15:8]+i_humi[7:0]+i_temp[15:8]+i_temp[7:0]) mod 256, computed as an 8-bit wrap.
  - Bit index = 39. Then enter ACK_LOW.
- o_busy = 1 from ACK_LOW through END_LOW inclusive.
- ACK_LOW: drive 0 for ACK_LOW_US, then ACK_HIGH.
- ACK_HIGH: release for ACK_HIGH_US, then BIT_LOW.
- BIT_LOW: drive 0 for BIT_LOW_US, then BIT_HIGH.
- BIT_HIGH: release for BIT1_HIGH_US if frame[idx]=1, else BIT0_HIGH_US.
  - If idx = 0: go to END_LOW.
  - Otherwise: decrement idx and go to BIT_LOW.
  - Transmission is MSB first: bit 39 = i_humi[15].
- END_LOW: drive 0 for END_LOW_US, release, pulse o_frame_done, go to IDLE.

Boundary conditions:
- i_humi/i_temp changes after the latch do not affect the frame in flight.
- The bus is not monitored from WAIT_REL to END_LOW; a host pulling low meanwhile has no effect.
- A new start is only detected after returning to IDLE.
- rst asserted mid-frame releases the bus in the same cycle (asynchronous); no o_frame_done pulse.
- A host low that never ends keeps HOST_LOW with the counter saturated; no response until release.
- Total frame from ACK_LOW start to release = 80+80+40*50+Σhigh+50 µs.

Decomposition:
- Package dht11_pkg:
  - state enum (IDLE, HOST_LOW, WAIT_REL, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, END_LOW);
  - default timing constants;
  - FRAME_BITS=40;
  - csum function.
- Sub-module dht11_us_tick: prescaler with synchronous clear input and one-cycle tick output.
- FSM, µs counter, shift/index logic and open-drain driver stay in dht11_sensor_emu.

Test Plan:
- Short start rejected: host drives low 10 ms then releases → bus stays z, no o_start_det, state IDLE.
- Nominal frame: i_humi=16'h3700, i_temp=16'h1905, 20 ms start → o_start_det.
  - Acknowledge: low 80 µs after 30 µs, released 80 µs.
  - 40 bits decode to 37 00 19 05 55.
  - o_frame_done 1 cycle after the 50 µs end low.
- Checksum wrap: i_humi=16'hFFFF, i_temp=16'hFF01 → fifth byte 8'hFE; bit high times all 70 µs except the zero bits at 26 µs ±0 cycles.
- Latch isolation: change i_temp to 16'h0000 during bit 10 → frame still carries 19 05 55; the next frame carries 00 00 37.
- Reset mid-frame: assert rst during BIT_LOW of bit 20 → dht11_io z within the same cycle, o_busy=0, no o_frame_done; a following 18 ms start yields a full correct frame.
- Exact threshold: host low of exactly 18000 µs accepted; low of 17999 µs rejected.
